// File: rtl/serial_frame_adder.sv
// Serial LSB-first frame adder: adds line1/line2 over FRAME_LEN-bit frames with abort detection.
// Optional subtract mode (line1 - line2) enabled by defining SERIAL_FRAME_ADDER_SUB_MODE_EN.
module serial_frame_adder #(
    parameter int FRAME_LEN  = 8,
    parameter bit OVF_STICKY = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 frame_start,
    input  logic                 line1,
    input  logic                 line2,
`ifdef SERIAL_FRAME_ADDER_SUB_MODE_EN
    input  logic                 sub,
`endif
    output logic                 outp,
    output logic                 out_valid,
    output logic [FRAME_LEN-1:0] sum_word,
    output logic                 word_valid,
    output logic                 overflw,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t               state_r, state_s;
    logic                 carry_r, carry_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [FRAME_LEN-2:0] partial_r, partial_s;
    logic                 sub_r, sub_s;
    logic                 sub_in_s;
    logic                 start_s, accept_s, last_s, abort_s;
    logic                 sub_mode_s, opb_s, cin_s, sum_bit_s, cout_s, ovf_s;
    logic [FRAME_LEN-2:0] base_s;
    logic [FRAME_LEN-1:0] word_s;
    logic                 outp_s, out_valid_s, word_valid_s, overflw_s, frame_err_s;
    logic [FRAME_LEN-1:0] sum_word_s;

`ifdef SERIAL_FRAME_ADDER_SUB_MODE_EN
    assign sub_in_s = sub;
`else
    assign sub_in_s = 1'b0;
`endif

    assign busy = (state_r == RUN);

    // Bit-serial datapath: accept qualification and one full-adder step.
    always_comb begin
        start_s = in_valid & frame_start;
        case (state_r)
            IDLE:    accept_s = start_s;
            RUN:     accept_s = in_valid;
            default: accept_s = 1'b0;
        endcase
        abort_s = start_s & (state_r == RUN);
        last_s  = in_valid & ~frame_start & (state_r == RUN) & (cnt_r == LAST_IDX);
        // A new frame takes its mode and carry-in from this cycle, not the held values.
        if (start_s) begin
            sub_mode_s = sub_in_s;
            cin_s      = sub_in_s;
            base_s     = '0;
        end else begin
            sub_mode_s = sub_r;
            cin_s      = carry_r;
            base_s     = partial_r;
        end
        opb_s     = line2 ^ sub_mode_s;
        sum_bit_s = line1 ^ opb_s ^ cin_s;
        cout_s    = maj3(line1, opb_s, cin_s);
        ovf_s     = sub_mode_s ? ~cout_s : cout_s;
        word_s    = {sum_bit_s, base_s};
    end

    // Next-state logic.
    always_comb begin
        case (state_r)
            IDLE: begin
                if (start_s) state_s = RUN;
                else         state_s = IDLE;
            end
            RUN: begin
                if (start_s)     state_s = RUN;
                else if (last_s) state_s = IDLE;
                else             state_s = RUN;
            end
            default: state_s = IDLE;
        endcase
    end

    // Next values for frame context and registered outputs.
    always_comb begin
        carry_s      = carry_r;
        cnt_s        = cnt_r;
        partial_s    = partial_r;
        sub_s        = sub_r;
        sum_word_s   = sum_word;
        outp_s       = accept_s ? sum_bit_s : outp;
        out_valid_s  = accept_s;
        word_valid_s = last_s;
        frame_err_s  = abort_s;
        if (start_s) begin
            carry_s   = cout_s;
            cnt_s     = CNT_W'(1);
            partial_s = word_s[FRAME_LEN-1:1];
            sub_s     = sub_mode_s;
        end else if (last_s) begin
            carry_s    = 1'b0;
            cnt_s      = '0;
            partial_s  = '0;
            sum_word_s = word_s;
        end else if (accept_s) begin
            carry_s   = cout_s;
            cnt_s     = cnt_r + CNT_W'(1);
            partial_s = word_s[FRAME_LEN-1:1];
        end else begin
            carry_s = carry_r;
        end
        // Sticky overflow survives idle time and is cleared only by an accepted frame_start.
        if (last_s)           overflw_s = ovf_s;
        else if (!OVF_STICKY) overflw_s = 1'b0;
        else if (start_s)     overflw_s = 1'b0;
        else                  overflw_s = overflw;
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Frame context and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            carry_r    <= 1'b0;
            cnt_r      <= '0;
            partial_r  <= '0;
            sub_r      <= 1'b0;
            outp       <= 1'b0;
            out_valid  <= 1'b0;
            sum_word   <= '0;
            word_valid <= 1'b0;
            overflw    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            carry_r    <= carry_s;
            cnt_r      <= cnt_s;
            partial_r  <= partial_s;
            sub_r      <= sub_s;
            outp       <= outp_s;
            out_valid  <= out_valid_s;
            sum_word   <= sum_word_s;
            word_valid <= word_valid_s;
            overflw    <= overflw_s;
            frame_err  <= frame_err_s;
        end
    end

endmodule

// File: tb/tb_serial_frame_adder.sv
// Directed self-checking bench for serial_frame_adder (FRAME_LEN=8), with a pulse and a sticky-overflow instance.
module tb_serial_frame_adder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic       line1 = 1'b0;
    logic       line2 = 1'b0;
    logic       sub = 1'b0;

    logic       outp, out_valid, word_valid, overflw, frame_err, busy;
    logic [7:0] sum_word;
    logic       s_outp, s_out_valid, s_word_valid, s_overflw, s_frame_err, s_busy;
    logic [7:0] s_sum_word;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_word = 8'h00;

    always #5 clock = ~clock;

    serial_frame_adder #(.FRAME_LEN(8), .OVF_STICKY(1'b0)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .frame_start(frame_start),
        .line1(line1), .line2(line2),
`ifdef SERIAL_FRAME_ADDER_SUB_MODE_EN
        .sub(sub),
`endif
        .outp(outp), .out_valid(out_valid), .sum_word(sum_word), .word_valid(word_valid),
        .overflw(overflw), .frame_err(frame_err), .busy(busy)
    );

    serial_frame_adder #(.FRAME_LEN(8), .OVF_STICKY(1'b1)) dut_sticky (
        .clock(clock), .reset(reset), .in_valid(in_valid), .frame_start(frame_start),
        .line1(line1), .line2(line2),
`ifdef SERIAL_FRAME_ADDER_SUB_MODE_EN
        .sub(sub),
`endif
        .outp(s_outp), .out_valid(s_out_valid), .sum_word(s_sum_word), .word_valid(s_word_valid),
        .overflw(s_overflw), .frame_err(s_frame_err), .busy(s_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic v, input logic fs, input logic a, input logic b);
        in_valid    = v;
        frame_start = fs;
        line1       = a;
        line2       = b;
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outp"}, 32'(outp), 32'h0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_sum_word"}, 32'(sum_word), 32'h0);
        check({tag, "_word_valid"}, 32'(word_valid), 32'h0);
        check({tag, "_overflw"}, 32'(overflw), 32'h0);
        check({tag, "_s_overflw"}, 32'(s_overflw), 32'h0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    // One full frame; optional stall (with a stray unqualified frame_start) after bit stall_at.
    task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] exp, input logic exp_ovf, input logic abort,
                             input int stall_at, input int stall_n, input logic sb);
        sub = sb;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, (i == 0), a[i], b[i]);
            check($sformatf("%s_ov%0d", tag, i), 32'(out_valid), 32'h1);
            check($sformatf("%s_outp%0d", tag, i), 32'(outp), 32'(exp[i]));
            check($sformatf("%s_wv%0d", tag, i), 32'(word_valid), 32'((i == 7)));
            check($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'((i != 7)));
            check($sformatf("%s_ferr%0d", tag, i), 32'(frame_err), 32'((i == 0) && abort));
            if (i == 7) begin
                check({tag, "_sum"}, 32'(sum_word), 32'(exp));
                check({tag, "_ovf"}, 32'(overflw), 32'(exp_ovf));
                check({tag, "_s_ovf"}, 32'(s_overflw), 32'(exp_ovf));
            end else begin
                check($sformatf("%s_hold%0d", tag, i), 32'(sum_word), 32'(exp_word));
                check($sformatf("%s_ovf%0d", tag, i), 32'(overflw), 32'h0);
                check($sformatf("%s_s_ovf%0d", tag, i), 32'(s_overflw), 32'h0);
            end
            if (i == stall_at) begin
                for (int k = 0; k < stall_n; k++) begin
                    send_bit(1'b0, 1'b1, 1'b1, 1'b1);
                    check($sformatf("%s_st_ov%0d", tag, k), 32'(out_valid), 32'h0);
                    check($sformatf("%s_st_busy%0d", tag, k), 32'(busy), 32'h1);
                    check($sformatf("%s_st_wv%0d", tag, k), 32'(word_valid), 32'h0);
                end
            end
        end
        exp_word = exp;
    endtask

    initial begin
        logic [7:0] pa;
        logic [7:0] pb;
        #2;
        check_all_zero("rst0");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Unqualified bit in IDLE is discarded.
        send_bit(1'b1, 1'b0, 1'b1, 1'b1);
        check("idle_discard_ov", 32'(out_valid), 32'h0);
        check("idle_discard_busy", 32'(busy), 32'h0);

        run_frame("add5a3c", 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0, -1, 0, 1'b0);
        // Back-to-back with no bubble.
        run_frame("addff01", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, -1, 0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0, 1'b0);
        check("ovf_pulse_end", 32'(overflw), 32'h0);
        check("ovf_sticky_hold1", 32'(s_overflw), 32'h1);
        check("wv_after", 32'(word_valid), 32'h0);
        send_bit(1'b0, 1'b0, 1'b0, 1'b0);
        check("ovf_sticky_hold2", 32'(s_overflw), 32'h1);

        run_frame("stall", 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0, 3, 3, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0, 1'b0);

        // Partial 0x11+0x22 (bits 0..4) aborted by the next frame_start.
        pa = 8'h11;
        pb = 8'h22;
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1, (i == 0), pa[i], pb[i]);
            check($sformatf("part_ov%0d", i), 32'(out_valid), 32'h1);
            check($sformatf("part_wv%0d", i), 32'(word_valid), 32'h0);
        end
        run_frame("abort", 8'h01, 8'h01, 8'h02, 1'b0, 1'b1, -1, 0, 1'b0);

        // Reset after bit 5 of a frame.
        pa = 8'h33;
        pb = 8'h44;
        for (int i = 0; i < 6; i++) begin
            send_bit(1'b1, (i == 0), pa[i], pb[i]);
        end
        in_valid = 1'b0;
        frame_start = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(posedge clock);
        #1;
        check_all_zero("rst_hold");
        reset = 1'b0;
        exp_word = 8'h00;
        send_bit(1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_wv", 32'(word_valid), 32'h0);
        check("post_rst_ferr", 32'(frame_err), 32'h0);
        run_frame("after_rst", 8'h03, 8'h04, 8'h07, 1'b0, 1'b0, -1, 0, 1'b0);

`ifdef SERIAL_FRAME_ADDER_SUB_MODE_EN
        send_bit(1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("sub1020", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, -1, 0, 1'b1);
        run_frame("sub2010", 8'h20, 8'h10, 8'h10, 1'b0, 1'b0, -1, 0, 1'b1);
        run_frame("sub0_add", 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0, -1, 0, 1'b0);
`endif

        send_bit(1'b0, 1'b0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_adder.md
Name: serial_frame_adder

Overview:
- Parametrised successor to the single-flow serial FSM: adds two serial bit streams (line1, line2), LSB-first, over frames of FRAME_LEN bits.
- Emits each registered sum bit (outp), the assembled frame word, and a carry-out overflow flag per frame.
- Adds valid/stall, frame delimiting, abort detection and an optional subtract mode.
- Sits at the serial-input front end, feeding word-oriented downstream logic.

Parameters:
- FRAME_LEN, 8, bits per frame; legal range 2..32; bit counter width is ceil(log2(FRAME_LEN)).
- OVF_STICKY, 0, 0: overflw is a one-cycle pulse with word_valid; 1: overflw holds until the next accepted frame_start or reset.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  line1/line2/frame_start are valid this cycle.
- frame_start  in  1  qualifies the current bit as bit 0 of a new frame.
- line1  in  1  serial operand A bit.
- line2  in  1  serial operand B bit.
- outp  out  1  registered sum bit.
- out_valid  out  1  outp valid; one cycle per consumed bit.
- sum_word  out  FRAME_LEN  completed frame sum; bit i = sum of frame bit i.
- word_valid  out  1  one-cycle pulse when sum_word is updated.
- overflw  out  1  carry-out of the completed frame.
- frame_err  out  1  one-cycle pulse when a frame is aborted.
- busy  out  1  high while in RUN.

Behaviour:
- Reset values: all outputs 0; state IDLE; carry 0; bit counter 0; shift register 0.
- States and transitions:
  - IDLE: in_valid & frame_start consumes bit 0 with carry-in 0 (1 in subtract mode), sets cnt=1, goes to RUN. in_valid without frame_start: bit discarded, no output.
  - RUN: each in_valid cycle consumes one bit: s=a^b^c, c_next=maj(a,b,c); cnt increments. in_valid=0: stall, all state held, out_valid=0.
  - Last bit (cnt==FRAME_LEN-1 consumed): returns to IDLE, clears carry.
- Latency:
  - outp/out_valid are registered 1 cycle after the consuming edge.
  - sum_word, word_valid and overflw update on the same cycle as the out_valid of the last bit.
  - overflw = final carry-out.
- sum_word holds its value between frames; the partial shift register is internal and not visible until frame completion.
- frame_start with in_valid while in RUN:
  - Aborts the partial frame: no word_valid, sum_word unchanged, frame_err pulses 1 cycle later.
  - The same bit is consumed as bit 0 of the new frame (carry reset, cnt=1); outp/out_valid are still produced for it.
- frame_start without in_valid is ignored.
- Back-to-back frames: frame_start on the cycle after the last bit is accepted with no bubble; word_valid of the old frame and out_valid of the new bit 0 may coincide.
- OVF_STICKY=1: overflw cleared when the next frame_start is accepted (registered), or by reset; a new frame's overflw overwrites it at word_valid.
- Reset asserted mid-frame: immediate return to reset values; no word_valid, no frame_err.
- busy = (state==RUN).

Optional Feature:
- Macro: SERIAL_FRAME_ADDER_SUB_MODE_EN.
- Defined:
  - Adds input port sub (1 bit), sampled only when frame_start is accepted and held for the frame.
  - sub=1 computes line1 - line2: line2 inverted, carry-in 1, overflw = borrow = NOT final carry-out.
  - sub=0 is identical to add mode.
- Undefined: port sub absent; add-only behaviour as above.

Test Plan:
- FRAME_LEN=8, A=0x5A, B=0x3C LSB-first, in_valid continuous -> outp stream 0,1,1,0,1,0,0,1; sum_word=0x96, word_valid 1 pulse, overflw=0, frame_err=0.
- A=0xFF, B=0x01 -> sum_word=0x00, overflw=1 (1 cycle with OVF_STICKY=0); repeat with OVF_STICKY=1 -> overflw stays 1 until the next frame_start, then 0.
- A=0x5A, B=0x3C with in_valid low 3 cycles after bit 3 -> busy stays 1, out_valid gaps, result identical to scenario 1 (0x96).
- Frame 0x11+0x22 aborted after bit 4 by frame_start, then full frame 0x01+0x01 -> frame_err 1 pulse, single word_valid with sum_word=0x02.
- reset asserted after bit 5, then frame 0x03+0x04 -> all outputs 0 during reset, then sum_word=0x07, overflw=0.
- SUB_MODE_EN, sub=1: 0x10-0x20 -> sum_word=0xF0, overflw=1; 0x20-0x10 -> sum_word=0x10, overflw=0.
